// File: rtl/div_pkg.sv
// Shared types and constants for the HI/LO divider and the EX-stage result select mux.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Result-select codes decoded by the downstream mux
  localparam logic [2:0] ALU_add  = 3'b010;
  localparam logic [2:0] ALU_sub  = 3'b110;
  localparam logic [2:0] ALU_and  = 3'b000;
  localparam logic [2:0] ALU_or   = 3'b001;
  localparam logic [2:0] ALU_slt  = 3'b111;
  localparam logic [2:0] SHT_sll  = 3'b011;
  localparam logic [2:0] DIV_mfhi = 3'b100;
  localparam logic [2:0] DIV_mflo = 3'b101;

endpackage

// File: rtl/hilo_divider_div_step.sv
// One combinational restoring-division iteration; the borrow of the
// WIDTH+1-bit subtraction is the compare result.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quot_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quot_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  assign shifted = {rem_in, quot_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign borrow  = diff[WIDTH];

  assign rem_out  = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quot_out = {quot_in[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/hilo_divider.sv
// Multi-cycle restoring divider holding HI (remainder) and LO (quotient).
// Define SIGNED_DIV_EN to honour SignedOp (MIPS DIV semantics); otherwise all ops are DIVU.
module hilo_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             SignedOp,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  div_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quot_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             divzero_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg_q_next;
  logic             neg_r_next;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quot;
  logic [WIDTH-1:0] fin_lo;
  logic [WIDTH-1:0] fin_hi;

`ifdef SIGNED_DIV_EN
  // Work on magnitudes; the signs are remembered and reapplied on the DONE load
  assign a_mag      = (SignedOp && dataA[WIDTH-1]) ? (~dataA + 1'b1) : dataA;
  assign b_mag      = (SignedOp && dataB[WIDTH-1]) ? (~dataB + 1'b1) : dataB;
  assign neg_q_next = SignedOp && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
  assign neg_r_next = SignedOp && dataA[WIDTH-1];
`else
  logic unused_signed_op;
  assign unused_signed_op = SignedOp;
  assign a_mag      = dataA;
  assign b_mag      = dataB;
  assign neg_q_next = 1'b0;
  assign neg_r_next = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (rem_reg),
    .quot_in  (quot_reg),
    .divisor  (divisor_reg),
    .rem_out  (step_rem),
    .quot_out (step_quot)
  );

  assign fin_lo = neg_q_reg ? (~step_quot + 1'b1) : step_quot;
  assign fin_hi = neg_r_reg ? (~step_rem + 1'b1) : step_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quot_reg    <= '0;
      divisor_reg <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      divzero_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (Start) begin
            busy_reg    <= 1'b1;
            divisor_reg <= b_mag;
            quot_reg    <= a_mag;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
            if (dataB == '0) begin
              state_reg   <= DONE;
              done_reg    <= 1'b1;
              divzero_reg <= 1'b1;
              lo_reg      <= '1;
              hi_reg      <= dataA;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg  <= step_rem;
          quot_reg <= step_quot;
          cnt_reg  <= cnt_reg + 1'b1;
          // The last iteration's result goes straight into HI/LO
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg   <= DONE;
            done_reg    <= 1'b1;
            divzero_reg <= 1'b0;
            lo_reg      <= fin_lo;
            hi_reg      <= fin_hi;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = busy_reg;
  assign Done    = done_reg;
  assign DivZero = divzero_reg;
  assign HiOut   = hi_reg;
  assign LoOut   = lo_reg;

endmodule

// File: tb/tb_hilo_divider.sv
// Scoreboard bench for hilo_divider: directed and random divides checked against plain arithmetic.
module tb_hilo_divider;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         Start;
  logic         SignedOp;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic         Busy;
  logic         Done;
  logic         DivZero;
  logic [W-1:0] HiOut;
  logic [W-1:0] LoOut;

  hilo_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .SignedOp (SignedOp),
    .dataA    (dataA),
    .dataB    (dataB),
    .Busy     (Busy),
    .Done     (Done),
    .DivZero  (DivZero),
    .HiOut    (HiOut),
    .LoOut    (LoOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int           done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: divide from the instruction's definition
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    e.done_cyc = 0;
    if (b == '0) begin
      e.lo = '1;
      e.hi = a;
      e.dz = 1'b1;
    end else begin
      e.dz = 1'b0;
      e.lo = a / b;
      e.hi = a % b;
`ifdef SIGNED_DIV_EN
      if (s) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = a;
          e.hi = '0;
        end else begin
          e.lo = $signed(a) / $signed(b);
          e.hi = $signed(a) % $signed(b);
        end
      end
`else
      if (s) e.dz = 1'b0;
`endif
    end
    return e;
  endfunction

  // Monitor: every Done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (reset && Done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("lo", LoOut, e.lo);
        check("hi", HiOut, e.hi);
        check("divzero", {31'd0, DivZero}, {31'd0, e.dz});
        check("done_cycle", cyc, e.done_cyc);
        check("busy_at_done", {31'd0, Busy}, 32'd1);
        $display("txn done cyc=%0d lo=0x%08h hi=0x%08h dz=%0d", cyc, LoOut, HiOut, DivZero);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit inject);
    exp_t e;
    int   n;
    @(negedge clk);
    dataA    = a;
    dataB    = b;
    SignedOp = s;
    Start    = 1'b1;
    e = model(a, b, s);
    e.done_cyc = cyc + 1 + ((b == '0) ? 0 : W);
    exp_q.push_back(e);
    $display("txn start a=0x%08h b=0x%08h s=%0d", a, b, s);
    @(negedge clk);
    Start = 1'b0;
    n = 0;
    while (Busy && n < 200) begin
      n++;
      if (inject && n == 10) begin
        dataA = 32'd50;
        dataB = 32'd5;
        Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_cycles", n, (b == '0) ? 1 : W + 1);
    repeat (2) @(negedge clk);
    check("hold_lo", LoOut, e.lo);
    check("hold_hi", HiOut, e.hi);
    check("hold_divzero", {31'd0, DivZero}, {31'd0, e.dz});
  endtask

  initial begin
    reset    = 1'b0;
    Start    = 1'b0;
    SignedOp = 1'b0;
    dataA    = '0;
    dataB    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_divzero", {31'd0, DivZero}, 32'd0);
    check("rst_hi", HiOut, 32'd0);
    check("rst_lo", LoOut, 32'd0);
    reset = 1'b1;

    do_op(32'd100, 32'd7, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    do_op(32'd5, 32'd9, 1'b0, 1'b0);
    do_op(32'h1234, 32'd0, 1'b0, 1'b0);
    do_op(32'd100, 32'd7, 1'b0, 1'b1);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(32'd3, 32'hFFFF_FFFE, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = $urandom_range(1, 16);
        2:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      do_op(a, b, 1'(($urandom_range(0, 1))), 1'($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of an operation abandons it without a Done pulse
    @(negedge clk);
    dataA = 32'd100;
    dataB = 32'd7;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, Busy}, 32'd0);
    check("async_rst_done", {31'd0, Done}, 32'd0);
    check("async_rst_divzero", {31'd0, DivZero}, 32'd0);
    check("async_rst_hi", HiOut, 32'd0);
    check("async_rst_lo", LoOut, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_rst", {31'd0, Busy}, 32'd0);

    do_op(32'd77, 32'd10, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
